display_scan: RTL and testbench
===============================

# display_scan

Upstream driver for the calculator's 7-segment BCD decoder. Accepts a binary result from the datapath, converts it to BCD with a sequential double-dabble engine, and time-multiplexes the digits onto the single shared decoder. Per slot it presents one BCD nibble on `data` and drives a one-hot, active-low digit enable. It also performs leading-zero blanking and overflow blanking.

## Interface
Parameters:
- `DIGITS`, default 4: number of multiplexed display digits.
- `VALUE_W`, default 14: width of the binary input value.
- `REFRESH_DIV`, default 50000: clock cycles each digit stays selected.

Ports:
- `clock`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `value`, in, `VALUE_W`: unsigned binary number to display.
- `load`, in, 1: one-cycle pulse. Samples `value` and starts conversion. Ignored while `busy`=1.
- `busy`, out, 1: conversion in progress.
- `overflow`, out, 1: last loaded value exceeds 10^`DIGITS`−1.
- `data`, out, 4: BCD digit to the decoder, always 0–9.
- `digit_en`, out, `DIGITS`: active-low one-hot digit select. All ones means the display is dark.

## Operation
- Converter FSM states: `IDLE` and `CONVERT`.
  - `IDLE` → `CONVERT` on `load`=1. On that edge:
    - shift register ← `value`
    - BCD accumulator ← 0
    - iteration counter ← 0
    - overflow candidate ← (`value` > 10^`DIGITS`−1)
  - In `CONVERT`, each cycle does one double-dabble iteration:
    - add 3 to every BCD nibble that is ≥5;
    - then shift {BCD, binary} left by 1.
  - After `VALUE_W` iterations: `CONVERT` → `IDLE`.
    - On that same edge, the display register ← BCD accumulator and `overflow` ← candidate. Both update atomically.
  - BCD width is 4·`DIGITS`. Any nibble carry beyond the top digit is discarded; the overflow flag covers that case.
- Scanner:
  - Refresh counter runs 0..`REFRESH_DIV`−1.
  - On wrap, scan index advances (index+1) mod `DIGITS`.
  - The scanner runs continuously and is independent of the converter. It shows the old display register until a conversion completes.
- Output register, updated every cycle from the current scan index i and display register:
  - `data` ← nibble i.
  - `digit_en` ← ~(1<<i), unless digit i is blanked.
  - Blanked means `digit_en` ← all ones and `data` ← 0.
- Blanking rules:
  - Digit i (i>0) is blanked when nibble i and every nibble above it are zero.
  - Digit 0 is never blanked by the leading-zero rule.
  - If `overflow`=1, every slot is blanked.

## Timing
- Reset values:
  - `busy`=0, `overflow`=0
  - display register=0, scan index=0, refresh counter=0
  - `data`=0, `digit_en`=all ones except bit 0 (4'b1110 for the default)
  - FSM=`IDLE`
- `load` accepted at edge t. `busy`=1 for cycles t+1 .. t+`VALUE_W` (exactly `VALUE_W` cycles). The display register updates on the edge where `busy` falls.
- New digits reach `data`/`digit_en` one cycle after the display register updates (registered outputs).
- `load` is ignored while `busy`=1, including the final conversion cycle. `load` in the first cycle with `busy`=0 is accepted.
- `value` is sampled only on the accepting edge. Later changes have no effect.
- Reset mid-conversion aborts the conversion:
  - `busy`=0 next cycle;
  - display returns to "0";
  - partial results are discarded.
- Each digit slot lasts exactly `REFRESH_DIV` cycles. The scan index wraps from `DIGITS`−1 to 0.

## Structure
- Package `display_pkg`:
  - converter state enum (`IDLE`, `CONVERT`);
  - BCD nibble typedef;
  - constant function for 10^N−1.
- Sub-module `bin2bcd`:
  - sequential double-dabble converter with the `load`/`busy` handshake;
  - outputs the BCD vector plus a done strobe.
- `display_scan` instantiates `bin2bcd` and contains the refresh counter, scan index, blanking logic and output register.

## Test plan
Benches use `REFRESH_DIV`=4 and defaults otherwise.

1. Reset held 2 cycles, then released → `busy`=0, `overflow`=0; for 16 cycles `digit_en` cycles 1110, 1111, 1111, 1111 (4 cycles each) with `data`=0.
2. `load` with `value`=1234 → `busy`=1 for exactly 14 cycles; afterwards a full scan shows (`data`,`digit_en`) = (4,1110), (3,1101), (2,1011), (1,0111), 4 cycles each.
3. `value`=1005 → digits 5, 0, 0, 1, all four enabled (no inner-zero blanking); `value`=7 → only 1110 with `data`=7, other slots 1111.
4. `value`=10000 → after 14 cycles `overflow`=1 and `digit_en`=1111 in every slot; then `value`=9999 → `overflow`=0, all digits show 9.
5. `load` 1234, then `load` 5678 on cycle 5 of conversion → 5678 ignored, display 1234; `load` 5678 on the first cycle after `busy` falls → accepted.
6. `load` 9999, then `reset` on cycle 7 → next cycle `busy`=0, display register 0, `digit_en`=1110, `data`=0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the display scan block: converter states,
// the BCD nibble type and the largest value that fits on N decimal digits.
package display_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } conv_state_t;

  typedef logic [3:0] bcd_t;

  function automatic longint max_decimal(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p - 1;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift iteration per cycle,
// VALUE_W cycles per conversion, with a done strobe on the final iteration.
module bin2bcd
  import display_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int VALUE_W = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int ITER_W = $clog2(VALUE_W + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(VALUE_W - 1);
  localparam longint MAX_VALUE = max_decimal(DIGITS);

  conv_state_t state, state_next;
  logic [VALUE_W-1:0] shift_reg;
  logic [VALUE_W-1:0] bin_step;
  logic [4*DIGITS-1:0] bcd_acc;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [4*DIGITS-1:0] bcd_step;
  logic [ITER_W-1:0] iter;
  logic ovf_cand;
  logic last_iter;

  assign last_iter = (iter == ITER_LAST);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // load is deliberately not looked at while converting, including the last cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CONVERT;
      CONVERT: if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONVERT);
    done = (state == CONVERT) && last_iter;
  end

  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[4*DIGITS-2:0], shift_reg[VALUE_W-1]};
    bin_step = {shift_reg[VALUE_W-2:0], 1'b0};
  end

  // A carry out of the top digit is simply dropped; ovf_cand flags that case
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg <= '0;
      bcd_acc   <= '0;
      iter      <= '0;
      ovf_cand  <= 1'b0;
    end else if (state == IDLE && load) begin
      shift_reg <= value;
      bcd_acc   <= '0;
      iter      <= '0;
      ovf_cand  <= (longint'(value) > MAX_VALUE);
    end else if (state == CONVERT) begin
      shift_reg <= bin_step;
      bcd_acc   <= bcd_step;
      iter      <= iter + 1'b1;
    end
  end

  assign bcd = bcd_step;
  assign ovf = ovf_cand;

endmodule

// File: rtl/display_scan.sv
// Drives the shared 7-segment BCD decoder: converts the loaded value to BCD
// and time-multiplexes digits with leading-zero and overflow blanking.
module display_scan
  import display_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int VALUE_W     = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  output logic               busy,
  output logic               overflow,
  output logic [3:0]         data,
  output logic [DIGITS-1:0]  digit_en
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] EN_DIGIT0 = ~DIGITS'(1);

  logic                conv_done;
  logic                conv_ovf;
  logic [4*DIGITS-1:0] conv_bcd;
  logic [4*DIGITS-1:0] display_reg;
  logic [CNT_W-1:0]    refresh_cnt;
  logic [IDX_W-1:0]    scan_idx;
  logic [DIGITS-1:0]   blank;
  bcd_t                sel_digit;
  logic                sel_blank;
  logic [DIGITS-1:0]   sel_en;

  bin2bcd #(
    .DIGITS  (DIGITS),
    .VALUE_W (VALUE_W)
  ) u_conv (
    .clock (clock),
    .reset (reset),
    .value (value),
    .load  (load),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  // Digits and overflow change together so the display never shows a mix
  always_ff @(posedge clock) begin
    if (reset) begin
      display_reg <= '0;
      overflow    <= 1'b0;
    end else if (conv_done) begin
      display_reg <= conv_bcd;
      overflow    <= conv_ovf;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
      scan_idx    <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (display_reg[4*i +: 4] == 4'd0);
      blank[i] = zero_run || overflow;
    end
    blank[0] = overflow;
  end

  always_comb begin
    sel_digit = '0;
    sel_blank = 1'b1;
    sel_en    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        sel_digit = display_reg[4*i +: 4];
        sel_blank = blank[i];
        sel_en    = '1;
        sel_en[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data     <= '0;
      digit_en <= EN_DIGIT0;
    end else if (sel_blank) begin
      data     <= '0;
      digit_en <= '1;
    end else begin
      data     <= sel_digit;
      digit_en <= sel_en;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: stimulus queues the expected digit scan,
// a negedge monitor checks one scan window after every conversion or reset.
module tb_display_scan;

  localparam int DIGITS       = 4;
  localparam int VALUE_W      = 14;
  localparam int REFRESH_DIV  = 4;
  localparam int CONV_CYCLES  = VALUE_W;
  // One sample short of a full scan so back-to-back conversions still fit
  localparam int SCAN_SAMPLES = REFRESH_DIV * DIGITS - 1;

  typedef struct {
    logic [15:0] data;
    logic [15:0] en;
    logic        ovf;
    string       name;
  } exp_t;

  logic               clock = 1'b0;
  logic               reset;
  logic               load;
  logic [VALUE_W-1:0] value;
  logic               busy;
  logic               overflow;
  logic [3:0]         data;
  logic [DIGITS-1:0]  digit_en;

  exp_t sb[$];
  exp_t cur;
  int   vectors     = 0;
  int   miscompares = 0;
  int   edges       = 0;
  int   remaining   = 0;
  logic active      = 1'b0;
  logic prev_busy   = 1'b0;

  always #5 clock = ~clock;

  display_scan #(
    .DIGITS      (DIGITS),
    .VALUE_W     (VALUE_W),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .busy     (busy),
    .overflow (overflow),
    .data     (data),
    .digit_en (digit_en)
  );

  always @(posedge clock) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  function automatic exp_t make_exp(input string name, input logic [15:0] d,
                                    input logic [15:0] en, input logic ovf);
    exp_t e;
    e.name = name;
    e.data = d;
    e.en   = en;
    e.ovf  = ovf;
    return e;
  endfunction

  // Monitor: a busy fall or the first edge out of reset opens a scan window
  initial begin
    int slot;
    forever begin
      @(negedge clock);
      if (active) begin
        slot = (edges == 0) ? 0 : ((edges - 1) / REFRESH_DIV) % DIGITS;
        check_output($sformatf("%s slot%0d", cur.name, slot),
                     {23'd0, overflow, data, digit_en},
                     {23'd0, cur.ovf, cur.data[slot*4 +: 4], cur.en[slot*4 +: 4]});
        remaining--;
        if (remaining == 0) active = 1'b0;
      end
      if (!active && ((prev_busy && !busy) || edges == 1)) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected display update: got busy=%b, want queued entry", busy);
        end else begin
          cur       = sb.pop_front();
          active    = 1'b1;
          remaining = SCAN_SAMPLES;
        end
      end
      prev_busy = busy;
    end
  end

  task automatic wait_busy(input string name);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clock);
    end
    check_output({name, " busy cycles"}, cnt, CONV_CYCLES);
  endtask

  task automatic apply_stimulus(input logic [VALUE_W-1:0] v, input exp_t e);
    sb.push_back(e);
    value = v;
    load  = 1'b1;
    @(negedge clock);
    load = 1'b0;
    wait_busy(e.name);
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((sb.size() != 0 || active) && i < 200) begin
      i++;
      @(negedge clock);
    end
    if (sb.size() != 0 || active) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    load  = 1'b0;
    value = '0;

    $display("[TB] reset and blank display");
    sb.push_back(make_exp("reset", 16'h0000, 16'hFFFE, 1'b0));
    repeat (2) @(negedge clock);
    check_output("reset busy", {31'd0, busy}, 32'd0);
    check_output("reset overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    wait_idle();

    $display("[TB] basic conversions");
    apply_stimulus(14'd1234, make_exp("1234", 16'h1234, 16'h7BDE, 1'b0));
    wait_idle();
    apply_stimulus(14'd1005, make_exp("1005", 16'h1005, 16'h7BDE, 1'b0));
    wait_idle();
    apply_stimulus(14'd7, make_exp("7", 16'h0007, 16'hFFFE, 1'b0));
    wait_idle();

    $display("[TB] overflow boundary");
    apply_stimulus(14'd10000, make_exp("10000", 16'h0000, 16'hFFFF, 1'b1));
    wait_idle();
    apply_stimulus(14'd9999, make_exp("9999", 16'h9999, 16'h7BDE, 1'b0));
    wait_idle();

    $display("[TB] load while busy, then load right after busy falls");
    sb.push_back(make_exp("1234 hold", 16'h1234, 16'h7BDE, 1'b0));
    value = 14'd1234;
    load  = 1'b1;
    @(negedge clock);
    load = 1'b0;
    cnt  = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (cnt == 5) begin
        value = 14'd5678;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clock);
    end
    load = 1'b0;
    check_output("1234 hold busy cycles", cnt, CONV_CYCLES);
    apply_stimulus(14'd5678, make_exp("5678", 16'h5678, 16'h7BDE, 1'b0));
    wait_idle();

    $display("[TB] reset during conversion");
    value = 14'd9999;
    load  = 1'b1;
    @(negedge clock);
    load = 1'b0;
    repeat (6) @(negedge clock);
    sb.push_back(make_exp("abort", 16'h0000, 16'hFFFE, 1'b0));
    reset = 1'b1;
    @(negedge clock);
    check_output("abort busy", {31'd0, busy}, 32'd0);
    check_output("abort outputs", {24'd0, data, digit_en}, {24'd0, 4'd0, 4'b1110});
    reset = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
